// File: rtl/signed_accum_pkg.sv
// Shared types and constants for the signed_accum8 block-sum stage.
//   state_e : block FSM state (ACCUM collects samples, HOLD presents the result)
//   DATA_W  : sample / sum width
//   SAT_MAX : positive clamp value
//   SAT_MIN : negative clamp value
package signed_accum_pkg;

   localparam int unsigned DATA_W = 8;

   localparam logic signed [DATA_W-1:0] SAT_MAX = 8'sh7F;
   localparam logic signed [DATA_W-1:0] SAT_MIN = 8'sh80;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_e;

endpackage

// File: rtl/sat_add8.sv
// Combinational 8-bit signed adder with overflow detect and optional clamp.
//   a_i      : running accumulator operand
//   b_i      : incoming sample operand
//   sat_en_i : 1 = clamp to SAT_MAX/SAT_MIN on overflow, 0 = wrap
//   sum_o    : result (raw or clamped)
//   ovf_o    : signed overflow of the raw add
module sat_add8
   import signed_accum_pkg::*;
(
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic              sat_en_i,
   output logic [DATA_W-1:0] sum_o,
   output logic              ovf_o
);

   logic [DATA_W-1:0] raw_sum;

   always_comb begin
      raw_sum = a_i + b_i;
      // Overflow only possible when operand signs agree and the result sign differs.
      ovf_o   = (a_i[DATA_W-1] == b_i[DATA_W-1]) && (raw_sum[DATA_W-1] != a_i[DATA_W-1]);
      sum_o   = raw_sum;
      if (sat_en_i && ovf_o) begin
         // Operand signs agree, so a_i's sign picks the clamp direction.
         sum_o = a_i[DATA_W-1] ? SAT_MIN : SAT_MAX;
      end
   end

endmodule

// File: rtl/signed_accum8.sv
// Block accumulator: sums N_SAMPLES signed 8-bit samples per block and holds
// the result under a valid/ready handshake until taken.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear_i      : synchronous abort, wins over accept and handoff
//   in_valid_i   : sample present      in_ready_o  : accepting (ACCUM)
//   in_data_i    : signed sample
//   out_valid_o  : result present (HOLD)  out_ready_i : result taken
//   out_sum_o    : block sum   out_ovf_o : sticky overflow   out_count_o : samples accepted
module signed_accum8
   import signed_accum_pkg::*;
#(
   parameter int unsigned N_SAMPLES = 8,
   parameter bit          SATURATE  = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_sum_o,
   output logic              out_ovf_o,
   output logic [7:0]        out_count_o
);

   localparam logic [7:0] LastCount = 8'(N_SAMPLES - 1);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [7:0]        count_q, count_d;
   logic              ovf_q, ovf_d;

   logic [DATA_W-1:0] add_sum;
   logic              add_ovf;

   sat_add8 u_sat_add8 (
      .a_i      (acc_q),
      .b_i      (in_data_i),
      .sat_en_i (SATURATE),
      .sum_o    (add_sum),
      .ovf_o    (add_ovf)
   );

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      count_d     = count_q;
      ovf_d       = ovf_q;
      // Handshake outputs depend on state only: no in_valid->in_ready or
      // out_ready->out_valid combinational path.
      in_ready_o  = (state_q == ACCUM);
      out_valid_o = (state_q == HOLD);

      if (clear_i) begin
         state_d = ACCUM;
         acc_d   = '0;
         count_d = '0;
         ovf_d   = 1'b0;
      end else begin
         unique case (state_q)
            ACCUM: begin
               if (in_valid_i) begin
                  acc_d   = add_sum;
                  ovf_d   = ovf_q | add_ovf;
                  count_d = count_q + 8'd1;
                  if (count_q == LastCount) begin
                     state_d = HOLD;
                  end
               end
            end
            HOLD: begin
               if (out_ready_i) begin
                  state_d = ACCUM;
                  acc_d   = '0;
                  count_d = '0;
                  ovf_d   = 1'b0;
               end
            end
            default: state_d = ACCUM;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign out_sum_o   = acc_q;
   assign out_ovf_o   = ovf_q;
   assign out_count_o = count_q;

endmodule
